// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared encodings for the memory bus controller and its arbiter.
package mem_bus_ctrl_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_e;
  localparam logic CH_INSTR = 1'b0;
  localparam logic CH_DATA = 1'b1;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic logic [3:0] lat_init(input int lat);
    return 4'(lat - 1);
  endfunction
endpackage

// File: rtl/mem_bus_ctrl_arb.sv
// rr_arbiter2: two-way arbiter, fixed data priority or round-robin with a data-favouring reset pointer.
module rr_arbiter2
  import mem_bus_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rr_mode,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);
  logic prio_d_q, prio_d_d;
  always_comb begin
    gnt_d = en & req_d & (~rr_mode | ~req_i | prio_d_q);
    gnt_i = en & req_i & ~gnt_d;
    prio_d_d = (gnt_i | gnt_d) ? gnt_i : prio_d_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prio_d_q <= 1'b1;
    else prio_d_q <= prio_d_d;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates fetch and load/store channels onto one memory bus with fixed latency.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int MEM_LATENCY = 2,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic                 i_rvalid,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 read_m,
  output logic                 write_m,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] i_count,
  output logic [WORD_SIZE-1:0] d_count
);
  localparam logic [3:0] LAT_INIT = lat_init(MEM_LATENCY);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ch_q, ch_d, we_q, we_d, i_rvalid_q, i_rvalid_d, d_done_q, d_done_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [WORD_SIZE-1:0] i_count_q, i_count_d, d_count_q, d_count_d;
  logic gnt_i, gnt_d, grant, last, i_fin, d_fin;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .rr_mode(ARB_MODE == ARB_RR),
    .en     (state_q == ST_IDLE),
    .req_i  (i_req),
    .req_d  (d_req),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ch_q       <= CH_INSTR;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_done_q   <= 1'b0;
      i_count_q  <= '0;
      d_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_done_q   <= d_done_d;
      i_count_q  <= i_count_d;
      d_count_q  <= d_count_d;
    end

  always_comb begin
    grant = gnt_i | gnt_d;
    last = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    state_d = (state_q == ST_IDLE) ? (grant ? ST_ACCESS : ST_IDLE) : (last ? ST_IDLE : ST_ACCESS);
  end

  // Completion is decided on the final strobe cycle so valid/done lands in the following IDLE cycle.
  always_comb begin
    i_fin = last & (ch_q == CH_INSTR);
    d_fin = last & (ch_q == CH_DATA);
    cnt_d = grant ? LAT_INIT : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    ch_d = grant ? (gnt_d ? CH_DATA : CH_INSTR) : ch_q;
    we_d = grant ? (gnt_d & d_we) : we_q;
    addr_d = grant ? (gnt_d ? d_addr : i_addr) : addr_q;
    wdata_d = gnt_d ? d_wdata : wdata_q;
    i_rdata_d = i_fin ? data : i_rdata_q;
    d_rdata_d = (d_fin & ~we_q) ? data : d_rdata_q;
    i_rvalid_d = i_fin;
    d_done_d = d_fin;
    i_count_d = i_count_q + WORD_SIZE'(i_fin);
    d_count_d = d_count_q + WORD_SIZE'(d_fin);
  end

  always_comb begin
    read_m = (state_q == ST_ACCESS) & ~we_q;
    write_m = (state_q == ST_ACCESS) & we_q;
    busy = state_q != ST_IDLE;
    i_ack = gnt_i;
    d_ack = gnt_d;
    address = addr_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    i_rvalid = i_rvalid_q;
    d_done = d_done_q;
    i_count = i_count_q;
    d_count = d_count_q;
  end

  assign data = write_m ? wdata_q : {WORD_SIZE{1'bz}};
endmodule
